// File: rtl/out_decimator.sv
// Output decimator: offset-binary to two's complement, pick/average by OSR,
// then a ready/valid FIFO toward the consumer. Never stalls upstream; overruns are flagged.
module out_decimator #(
    parameter int OUT_WIDTH  = 24,
    parameter int OSR        = 1,
    parameter int MODE       = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [OUT_WIDTH-1:0]                 in_data,
    input  logic                                 in_valid,
    output logic [OUT_WIDTH-1:0]                 out_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fill,
    output logic                                 overflow
);

    localparam int LOG2  = $clog2(OSR);
    localparam int PH_W  = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int ACC_W = OUT_WIDTH + LOG2;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FW    = $clog2(FIFO_DEPTH + 1);

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OSR - 1);

    logic signed [OUT_WIDTH-1:0] s;
    logic [PH_W-1:0]             ph;
    logic [OUT_WIDTH-1:0]        stage;
    logic                        stageV;

    // Flipping the MSB turns offset-binary into two's complement.
    assign s = {~in_data[OUT_WIDTH-1], in_data[OUT_WIDTH-2:0]};

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ph <= '0;
        end else if (!in_valid || ph == PH_LAST) begin
            ph <= '0;
        end else begin
            ph <= ph + PH_W'(1);
        end
    end

    generate
        if (MODE == 1) begin : gAvg
            logic signed [ACC_W-1:0] acc;
            logic signed [ACC_W-1:0] sExt;
            logic signed [ACC_W-1:0] accNext;

            assign sExt    = ACC_W'(s);
            // Phase 0 starts a fresh group, so a stale partial sum never leaks in.
            assign accNext = ((ph == '0) ? '0 : acc) + sExt;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    acc    <= '0;
                    stage  <= '0;
                    stageV <= 1'b0;
                end else begin
                    stageV <= 1'b0;
                    if (in_valid) begin
                        acc <= accNext;
                        if (ph == PH_LAST) begin
                            stage  <= OUT_WIDTH'(accNext >>> LOG2);
                            stageV <= 1'b1;
                        end
                    end
                end
            end
        end else begin : gPick
            always_ff @(posedge clk) begin
                if (!rst) begin
                    stage  <= '0;
                    stageV <= 1'b0;
                end else begin
                    stageV <= in_valid && (ph == '0);
                    if (in_valid && ph == '0) begin
                        stage <= s;
                    end
                end
            end
        end
    endgenerate

    logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wrPtr;
    logic [AW-1:0]        rdPtr;
    logic                 full;
    logic                 doPop;
    logic                 doPush;

    assign out_valid = (fill != '0);
    assign full      = (fill == FW'(FIFO_DEPTH));
    assign doPop     = out_valid && out_ready;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign doPush    = stageV && (!full || doPop);
    assign out_data  = out_valid ? mem[rdPtr] : '0;

    // NOTE: the storage array has no reset; fill gates its contents, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= stage;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            fill     <= '0;
            overflow <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            case ({doPush, doPop})
                2'b10:   fill <= fill + FW'(1);
                2'b01:   fill <= fill - FW'(1);
                default: fill <= fill;
            endcase
            if (stageV && !doPush) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_out_decimator.sv
// Directed bench for out_decimator: four configurations share one stimulus stream;
// each test checks the instance it targets against hand-computed values.
module tb_out_decimator;

    logic        clk;
    logic        rst;
    logic [23:0] inData;
    logic        inValid;
    logic        outReady;

    logic [23:0] aData, bData, cData, dData;
    logic        aValid, bValid, cValid, dValid;
    logic [4:0]  aFill, bFill, cFill;
    logic [2:0]  dFill;
    logic        aOvf, bOvf, cOvf, dOvf;

    int nChecks = 0;
    int nPass   = 0;

    logic [23:0] qB[$];
    logic [23:0] qC[$];
    logic [23:0] qD[$];
    logic [23:0] expQ[$];

    // A: OSR=1 pick, B: OSR=4 pick, C: OSR=4 average, D: OSR=1 pick with a 4-deep FIFO
    out_decimator #(.OUT_WIDTH(24), .OSR(1), .MODE(0), .FIFO_DEPTH(16)) uA (
        .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid),
        .out_data(aData), .out_valid(aValid), .out_ready(outReady), .fill(aFill), .overflow(aOvf));
    out_decimator #(.OUT_WIDTH(24), .OSR(4), .MODE(0), .FIFO_DEPTH(16)) uB (
        .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid),
        .out_data(bData), .out_valid(bValid), .out_ready(outReady), .fill(bFill), .overflow(bOvf));
    out_decimator #(.OUT_WIDTH(24), .OSR(4), .MODE(1), .FIFO_DEPTH(16)) uC (
        .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid),
        .out_data(cData), .out_valid(cValid), .out_ready(outReady), .fill(cFill), .overflow(cOvf));
    out_decimator #(.OUT_WIDTH(24), .OSR(1), .MODE(0), .FIFO_DEPTH(4)) uD (
        .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid),
        .out_data(dData), .out_valid(dValid), .out_ready(outReady), .fill(dFill), .overflow(dOvf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted sample midway between edges.
    always @(negedge clk) begin
        if (rst && outReady) begin
            if (bValid) qB.push_back(bData);
            if (cValid) qC.push_back(cData);
            if (dValid) qD.push_back(dData);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            nPass++;
        end
    endtask

    task automatic cmpQ(input string tag, input logic [23:0] got[$]);
        check({tag, " count"}, got.size(), expQ.size());
        foreach (expQ[i]) begin
            check($sformatf("%s[%0d]", tag, i),
                  (i < got.size()) ? {8'h0, got[i]} : 32'hDEAD_BEEF, {8'h0, expQ[i]});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [23:0] d);
        inValid = 1'b1;
        inData  = d;
        step();
    endtask

    task automatic idle(input int n);
        inValid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic doReset();
        rst     = 1'b0;
        inValid = 1'b0;
        step();
        rst = 1'b1;
        qB.delete();
        qC.delete();
        qD.delete();
    endtask

    initial begin
        rst      = 1'b0;
        inValid  = 1'b0;
        inData   = '0;
        outReady = 1'b0;
        step();
        step();
        check("rst aValid", aValid, 0);
        check("rst aData", aData, 0);
        check("rst aFill", aFill, 0);
        check("rst aOvf", aOvf, 0);
        check("rst dFill", dFill, 0);
        check("rst dOvf", dOvf, 0);

        // OSR=1 pass-through with two-cycle latency and no bypass
        rst      = 1'b1;
        outReady = 1'b1;
        feed(24'h800000);
        check("t1 no bypass", aValid, 0);
        feed(24'h7FFFFF);
        check("t1 v0", aValid, 1);
        check("t1 d0", aData, 24'h000000);
        check("t1 f0", aFill, 1);
        feed(24'h000000);
        check("t1 d1", aData, 24'hFFFFFF);
        check("t1 f1", aFill, 1);
        idle(1);
        check("t1 d2", aData, 24'h800000);
        check("t1 f2", aFill, 1);
        idle(1);
        check("t1 empty v", aValid, 0);
        check("t1 empty d", aData, 0);
        check("t1 empty f", aFill, 0);

        // OSR=4 pick with phase realignment on every rise of in_valid
        doReset();
        outReady = 1'b1;
        for (int j = 1; j <= 8; j++) feed(24'h800000 + 24'(j));
        idle(1);
        for (int j = 0; j < 3; j++) feed(24'h800010 + 24'(j));
        idle(1);
        feed(24'h800020);
        feed(24'h800021);
        idle(1);
        feed(24'h800030);
        feed(24'h800031);
        idle(4);
        expQ = {24'h000001, 24'h000005, 24'h000010, 24'h000020, 24'h000030};
        cmpQ("pick", qB);

        // OSR=4 boxcar: floor on positive and negative sums, partial group discarded
        doReset();
        outReady = 1'b1;
        feed(24'h800003);
        feed(24'h800004);
        feed(24'h7FFFFF);
        feed(24'h800000);
        check("avg lat k", cValid, 0);
        feed(24'h7FFFFF);
        check("avg lat k+1 v", cValid, 1);
        check("avg lat k+1 d", cData, 24'h000001);
        for (int j = 0; j < 3; j++) feed(24'h7FFFFF);
        feed(24'h7FFFFF);
        for (int j = 0; j < 3; j++) feed(24'h800000);
        feed(24'h800100);
        feed(24'h800100);
        idle(1);
        for (int j = 0; j < 4; j++) feed(24'h800008);
        idle(4);
        expQ = {24'h000001, 24'hFFFFFF, 24'hFFFFFF, 24'h000008};
        cmpQ("avg", qC);

        // 4-deep FIFO overrun: samples 5 and 6 dropped, overflow sticky through the drain
        doReset();
        outReady = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            feed(24'h800000 + 24'(j));
            if (j == 5) begin
                check("ovr fill4", dFill, 4);
                check("ovr not yet", dOvf, 0);
            end
        end
        check("ovr set", dOvf, 1);
        idle(1);
        check("ovr fill hold", dFill, 4);
        check("ovr head", dData, 24'h000001);
        outReady = 1'b1;
        idle(5);
        expQ = {24'h000001, 24'h000002, 24'h000003, 24'h000004};
        cmpQ("ovr", qD);
        check("ovr sticky", dOvf, 1);
        check("ovr drained", dFill, 0);

        // Full FIFO with simultaneous push and pop, across pointer wrap
        doReset();
        outReady = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            if (j == 6) outReady = 1'b1;
            feed(24'h800010 + 24'(j));
            if (j >= 6) check($sformatf("pp fill e%0d", j), dFill, 4);
        end
        idle(1);
        check("pp fill e9", dFill, 4);
        check("pp no ovf", dOvf, 0);
        idle(5);
        expQ = {24'h000011, 24'h000012, 24'h000013, 24'h000014,
                24'h000015, 24'h000016, 24'h000017, 24'h000018};
        cmpQ("pp", qD);

        // Reset with fill=3 and a half-accumulated group
        doReset();
        outReady = 1'b0;
        for (int j = 0; j < 12; j++) feed(24'h800001);
        feed(24'h800005);
        feed(24'h800005);
        check("mid fill3", cFill, 3);
        rst     = 1'b0;
        inValid = 1'b1;
        inData  = 24'h7FFFFF;
        step();
        check("mid rst v", cValid, 0);
        check("mid rst d", cData, 0);
        check("mid rst f", cFill, 0);
        check("mid rst o", cOvf, 0);
        rst = 1'b1;
        qC.delete();
        for (int j = 0; j < 3; j++) feed(24'h800002);
        feed(24'h800006);
        outReady = 1'b1;
        idle(4);
        expQ = {24'h000003};
        cmpQ("mid", qC);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
